// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: MEM-priority grant between fetch and load/store,
// registered bus handshake, fetch drop on redirect, starvation guard and bus timeout.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        flush,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        timeout_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, BUSY_IF, BUSY_MEM
  } state_e;

  state_e state_q, state_d;

  logic          breq_q, breq_d;
  logic          bwe_q, bwe_d;
  logic [31:0]   baddr_q, baddr_d;
  logic [31:0]   bwdata_q, bwdata_d;
  logic [3:0]    bstrb_q, bstrb_d;
  logic [31:0]   ifr_q, ifr_d;
  logic          ifv_q, ifv_d;
  logic [31:0]   memr_q, memr_d;
  logic          memv_q, memv_d;
  logic          drop_q, drop_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          err_q, err_d;

  logic if_pend, mem_pend, mem_win, done;

  // A requester in its own valid cycle still shows the request just served.
  assign if_pend  = if_req && !ifv_q;
  assign mem_pend = mem_req && !memv_q;
  assign mem_win  = mem_pend && (!if_pend || (starve_q < SLIM));
  assign done     = bus_ack || (tmo_q == TLAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_win)      state_d = BUSY_MEM;
        else if (if_pend) state_d = BUSY_IF;
      end
      BUSY_IF, BUSY_MEM: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    breq_d   = breq_q;
    bwe_d    = bwe_q;
    baddr_d  = baddr_q;
    bwdata_d = bwdata_q;
    bstrb_d  = bstrb_q;
    ifr_d    = ifr_q;
    ifv_d    = 1'b0;
    memr_d   = memr_q;
    memv_d   = 1'b0;
    drop_d   = drop_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        tmo_d  = '0;
        drop_d = 1'b0;
        if (mem_win) begin
          breq_d   = 1'b1;
          bwe_d    = mem_we;
          baddr_d  = mem_addr;
          bwdata_d = mem_wdata;
          bstrb_d  = mem_we ? mem_wstrb : 4'b0000;
          starve_d = starve_q + SW'(if_pend);
        end else if (if_pend) begin
          breq_d   = 1'b1;
          bwe_d    = 1'b0;
          baddr_d  = if_addr;
          bwdata_d = '0;
          bstrb_d  = 4'b0000;
          starve_d = '0;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (done) begin
          breq_d = 1'b0;
          tmo_d  = '0;
          drop_d = 1'b0;
          err_d  = err_q | !bus_ack;
          if (state_q == BUSY_IF) begin
            if (!(drop_q || flush)) begin
              ifv_d = 1'b1;
              ifr_d = bus_ack ? bus_rdata : '0;
            end
          end else begin
            memv_d = 1'b1;
            if (!bwe_q) memr_d = bus_ack ? bus_rdata : '0;
          end
        end else begin
          tmo_d  = tmo_q + 8'd1;
          drop_d = drop_q | (flush && (state_q == BUSY_IF));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      breq_q   <= 1'b0;
      bwe_q    <= 1'b0;
      baddr_q  <= '0;
      bwdata_q <= '0;
      bstrb_q  <= '0;
      ifr_q    <= '0;
      ifv_q    <= 1'b0;
      memr_q   <= '0;
      memv_q   <= 1'b0;
      drop_q   <= 1'b0;
      starve_q <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      breq_q   <= breq_d;
      bwe_q    <= bwe_d;
      baddr_q  <= baddr_d;
      bwdata_q <= bwdata_d;
      bstrb_q  <= bstrb_d;
      ifr_q    <= ifr_d;
      ifv_q    <= ifv_d;
      memr_q   <= memr_d;
      memv_q   <= memv_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    if_rdata    = ifr_q;
    if_valid    = ifv_q;
    if_stall    = if_req && !ifv_q;
    mem_rdata   = memr_q;
    mem_valid   = memv_q;
    mem_stall   = mem_req && !memv_q;
    bus_req     = breq_q;
    bus_we      = bwe_q;
    bus_addr    = baddr_q;
    bus_wdata   = bwdata_q;
    bus_wstrb   = bstrb_q;
    timeout_err = err_q;
  end
endmodule
